// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving a big-endian req/ack data bus.
// Optional feature macro BUS_TIMEOUT_EN: abandon a REQ after TIMEOUT_CYCLES and pulse bus_err.
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b11100000
`define EXE_LH_OP  8'b11100001
`define EXE_LW_OP  8'b11100011
`define EXE_LBU_OP 8'b11100100
`define EXE_LHU_OP 8'b11100101
`define EXE_SB_OP  8'b11101000
`define EXE_SH_OP  8'b11101001
`define EXE_SW_OP  8'b11101011
`endif
`ifndef writeDisable
`define writeDisable 1'b0
`endif
`ifndef NOPRegAddr
`define NOPRegAddr 5'b00000
`endif

module mem_lsu
`ifdef BUS_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 16)
`endif
  (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [31:0] mem_hi_i,
  input  logic [31:0] mem_lo_i,
  input  logic        mem_hilo_i,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_hilo,
  output logic        stallreq,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        misalign,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d, result_q, result_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [4:0]  wd_q, wd_d;
  logic        wreg_q, wreg_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
`ifdef BUS_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
`endif

  logic        is_load_s, is_store_s, is_mem_s, aligned_s;
  size_t       size_s;
  logic [3:0]  sel_s;
  logic [31:0] st_data_s, ld_data_s;
  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;
  logic        unused_stall_s;

  assign unused_stall_s = ^{stall[5], stall[3:0]};
  assign is_mem_s = is_load_s | is_store_s;

  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    size_s     = SZ_W;
    case (mem_aluop_i)
      `EXE_LB_OP, `EXE_LBU_OP: begin is_load_s = 1'b1; size_s = SZ_B; end
      `EXE_LH_OP, `EXE_LHU_OP: begin is_load_s = 1'b1; size_s = SZ_H; end
      `EXE_LW_OP:              is_load_s = 1'b1;
      `EXE_SB_OP:              begin is_store_s = 1'b1; size_s = SZ_B; end
      `EXE_SH_OP:              begin is_store_s = 1'b1; size_s = SZ_H; end
      `EXE_SW_OP:              is_store_s = 1'b1;
      default:                 is_load_s = 1'b0;
    endcase
  end

  // Big-endian lane select and store-data replication.
  always_comb begin
    case (size_s)
      SZ_B: begin
        aligned_s = 1'b1;
        sel_s     = 4'b1000 >> mem_addr_i[1:0];
        st_data_s = {4{mem_reg2_i[7:0]}};
      end
      SZ_H: begin
        aligned_s = ~mem_addr_i[0];
        sel_s     = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        st_data_s = {2{mem_reg2_i[15:0]}};
      end
      default: begin
        aligned_s = (mem_addr_i[1:0] == 2'b00);
        sel_s     = 4'b1111;
        st_data_s = mem_reg2_i;
      end
    endcase
  end

  always_comb begin
    case (off_q)
      2'b00:   ld_byte_s = bus_rdata[31:24];
      2'b01:   ld_byte_s = bus_rdata[23:16];
      2'b10:   ld_byte_s = bus_rdata[15:8];
      default: ld_byte_s = bus_rdata[7:0];
    endcase
    ld_half_s = off_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    case (op_q)
      `EXE_LB_OP:  ld_data_s = {{24{ld_byte_s[7]}}, ld_byte_s};
      `EXE_LBU_OP: ld_data_s = {24'h000000, ld_byte_s};
      `EXE_LH_OP:  ld_data_s = {{16{ld_half_s[15]}}, ld_half_s};
      `EXE_LHU_OP: ld_data_s = {16'h0000, ld_half_s};
      `EXE_LW_OP:  ld_data_s = bus_rdata;
      default:     ld_data_s = result_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    result_d    = result_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    op_d        = op_q;
    off_d       = off_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (is_mem_s && aligned_s) begin
          state_d     = REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store_s;
          bus_addr_d  = {mem_addr_i[31:2], 2'b00};
          bus_sel_d   = sel_s;
          bus_wdata_d = st_data_s;
          result_d    = mem_wdata_i;
          wd_d        = mem_wd_i;
          wreg_d      = mem_wreg_i;
          op_d        = mem_aluop_i;
          off_d       = mem_addr_i[1:0];
`ifdef BUS_TIMEOUT_EN
          cnt_d       = 8'h00;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // An ack in the timeout cycle still completes the access normally.
        if (bus_ack) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          result_d  = ld_data_s;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          wreg_d    = 1'b0;
          result_d  = 32'h00000000;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
`else
        else begin
          state_d = REQ;
        end
`endif
      end
      DONE: begin
        if (stall[4]) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MEM/WB-facing outputs; reset forces a bubble even before the next edge.
  always_comb begin
    mem_wd    = `NOPRegAddr;
    mem_wreg  = `writeDisable;
    mem_wdata = 32'h00000000;
    mem_hi    = 32'h00000000;
    mem_lo    = 32'h00000000;
    mem_hilo  = 1'b0;
    stallreq  = 1'b0;
    misalign  = 1'b0;
    if (!rst) begin
      stallreq = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mem_wd    = mem_wd_i;
          mem_wreg  = mem_wreg_i & ~is_mem_s;
          mem_wdata = mem_wdata_i;
          mem_hi    = mem_hi_i;
          mem_lo    = mem_lo_i;
          mem_hilo  = mem_hilo_i;
          misalign  = is_mem_s & ~aligned_s;
          stallreq  = is_mem_s & aligned_s;
        end
        REQ: begin
          mem_wd   = wd_q;
          stallreq = 1'b1;
        end
        DONE: begin
          mem_wd    = wd_q;
          mem_wreg  = wreg_q;
          mem_wdata = result_q;
        end
        default: stallreq = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h00000000;
      bus_sel_q   <= 4'h0;
      bus_wdata_q <= 32'h00000000;
      result_q    <= 32'h00000000;
      wd_q        <= 5'h00;
      wreg_q      <= 1'b0;
      op_q        <= 8'h00;
      off_q       <= 2'b00;
`ifdef BUS_TIMEOUT_EN
      cnt_q       <= 8'h00;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      result_q    <= result_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      op_q        <= op_d;
      off_q       <= off_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;
`ifdef BUS_TIMEOUT_EN
  assign bus_err   = bus_err_q;
`else
  assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: vector table, hand sequences and a randomized model check.
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b11100000
`define EXE_LH_OP  8'b11100001
`define EXE_LW_OP  8'b11100011
`define EXE_LBU_OP 8'b11100100
`define EXE_LHU_OP 8'b11100101
`define EXE_SB_OP  8'b11101000
`define EXE_SH_OP  8'b11101001
`define EXE_SW_OP  8'b11101011
`endif
`ifndef EXE_ADD_OP
`define EXE_ADD_OP 8'b00100000
`endif

module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i, mem_hilo_i, bus_ack;
  logic [31:0] mem_wdata_i, mem_hi_i, mem_lo_i, mem_addr_i, mem_reg2_i, bus_rdata;
  logic [7:0]  mem_aluop_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_hilo, stallreq, bus_req, bus_we, misalign, bus_err;
  logic [31:0] mem_wdata, mem_hi, mem_lo, bus_addr, bus_wdata;
  logic [3:0]  bus_sel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

`ifdef BUS_TIMEOUT_EN
  mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
`else
  mem_lsu dut (
`endif
    .clk(clk), .rst(rst), .stall(stall),
    .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
    .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i), .mem_hilo_i(mem_hilo_i),
    .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_hilo(mem_hilo),
    .stallreq(stallreq), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .misalign(misalign), .bus_err(bus_err)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] rdata;
    int          waits;
    int          hold;
    logic        e_mis;
    logic [3:0]  e_sel;
    logic [31:0] e_bwd;
    logic [31:0] e_res;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                              input logic [31:0] wdata, input logic [4:0] wd, input logic wreg,
                              input logic [31:0] rdata, input int waits, input int hold,
                              input logic e_mis, input logic [3:0] e_sel, input logic [31:0] e_bwd,
                              input logic [31:0] e_res);
    vec_t v;
    v.op = op; v.addr = addr; v.reg2 = reg2; v.wdata = wdata; v.wd = wd; v.wreg = wreg;
    v.rdata = rdata; v.waits = waits; v.hold = hold;
    v.e_mis = e_mis; v.e_sel = e_sel; v.e_bwd = e_bwd; v.e_res = e_res;
    return v;
  endfunction

  // Access size in bytes, 0 for non-memory operations.
  function automatic int sz(input logic [7:0] op);
    case (op)
      `EXE_LB_OP, `EXE_LBU_OP, `EXE_SB_OP: return 1;
      `EXE_LH_OP, `EXE_LHU_OP, `EXE_SH_OP: return 2;
      `EXE_LW_OP, `EXE_SW_OP:              return 4;
      default:                             return 0;
    endcase
  endfunction

  function automatic logic is_ld(input logic [7:0] op);
    return op inside {`EXE_LB_OP, `EXE_LBU_OP, `EXE_LH_OP, `EXE_LHU_OP, `EXE_LW_OP};
  endfunction

  // Reference model: byte k of a big-endian word lives at bits [31-8k -: 8].
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int n, off;
    logic [63:0] mask, val;
    r = v;
    n = sz(v.op);
    off = int'(v.addr[1:0]);
    r.e_mis = (n != 0) && ((off % n) != 0);
    r.e_sel = 4'h0;
    r.e_bwd = 32'h0;
    r.e_res = v.wdata;
    if (n != 0 && !r.e_mis) begin
      mask = (64'd1 << (8 * n)) - 64'd1;
      for (int i = 0; i < n; i++) r.e_sel[3 - off - i] = 1'b1;
      for (int i = 0; i < 4 / n; i++) r.e_bwd = r.e_bwd | 32'((64'(v.reg2) & mask) << (8 * n * i));
      if (is_ld(v.op)) begin
        val = (64'(v.rdata) >> (8 * (4 - off - n))) & mask;
        if ((v.op == `EXE_LB_OP || v.op == `EXE_LH_OP) && val[8 * n - 1]) val = val | ~mask;
        r.e_res = val[31:0];
      end
    end
    return r;
  endfunction

  // One instruction through the stage; starts and ends 1 time unit after a rising edge.
  task automatic run(input vec_t v);
    int sc;
    logic [31:0] hi, lo;
    logic hl;
    hi = $urandom; lo = $urandom; hl = 1'($urandom);
    mem_aluop_i = v.op; mem_addr_i = v.addr; mem_reg2_i = v.reg2; mem_wdata_i = v.wdata;
    mem_wd_i = v.wd; mem_wreg_i = v.wreg; mem_hi_i = hi; mem_lo_i = lo; mem_hilo_i = hl;
    bus_ack = 1'b0; stall = 6'b0; bus_rdata = $urandom;
    #2;
    chk("idle_bus_req", bus_req, 32'h0);
    chk("misalign", misalign, v.e_mis);
    sc = int'(stallreq);
    if (sz(v.op) == 0) begin
      chk("pt_wd", mem_wd, v.wd);
      chk("pt_wreg", mem_wreg, v.wreg);
      chk("pt_wdata", mem_wdata, v.wdata);
      chk("pt_hi", mem_hi, hi);
      chk("pt_lo", mem_lo, lo);
      chk("pt_hilo", mem_hilo, hl);
      chk("pt_stallreq", stallreq, 32'h0);
    end else if (v.e_mis) begin
      chk("mis_stallreq", stallreq, 32'h0);
      chk("mis_wreg", mem_wreg, 32'h0);
    end else begin
      chk("idle_stallreq", stallreq, 32'h1);
    end
    tick();
    if (sz(v.op) == 0 || v.e_mis) begin
      bus_ack = 1'($urandom);
      #2;
      chk("no_bus_req", bus_req, 32'h0);
      tick();
      bus_ack = 1'b0;
    end else begin
      for (int w = 0; w <= v.waits; w++) begin
        bus_ack = (w == v.waits);
        bus_rdata = (w == v.waits) ? v.rdata : $urandom;
        #2;
        sc += int'(stallreq);
        chk("req_bus_req", bus_req, 32'h1);
        chk("req_bus_we", bus_we, !is_ld(v.op));
        chk("req_bus_addr", bus_addr, {v.addr[31:2], 2'b00});
        chk("req_bus_sel", bus_sel, v.e_sel);
        if (!is_ld(v.op)) chk("req_bus_wdata", bus_wdata, v.e_bwd);
        tick();
      end
      bus_ack = 1'($urandom);
      bus_rdata = $urandom;
      for (int h = 0; h <= v.hold; h++) begin
        stall[4] = (h < v.hold);
        #2;
        sc += int'(stallreq);
        chk("done_stallreq", stallreq, 32'h0);
        chk("done_bus_req", bus_req, 32'h0);
        chk("done_wd", mem_wd, v.wd);
        chk("done_wreg", mem_wreg, v.wreg);
        chk("done_wdata", mem_wdata, v.e_res);
        chk("done_hilo", mem_hilo, 32'h0);
        chk("done_bus_err", bus_err, 32'h0);
        tick();
      end
      stall = 6'b0;
      bus_ack = 1'b0;
      chk("stall_cycles", sc, v.waits + 2);
    end
  endtask

  logic [7:0] ops[9];

  initial begin
    tbl[0]  = mk(`EXE_ADD_OP, 32'h0,   32'h0,        32'h1234, 5'd5,  1'b1, 32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,        32'h1234);
    tbl[1]  = mk(`EXE_LB_OP,  32'h103, 32'h0,        32'h0,    5'd8,  1'b1, 32'h000000F0, 2, 0, 1'b0, 4'b0001, 32'h0,        32'hFFFFFFF0);
    tbl[2]  = mk(`EXE_SH_OP,  32'h202, 32'hABCD1234, 32'h202,  5'd0,  1'b0, 32'h0,        0, 0, 1'b0, 4'b0011, 32'h12341234, 32'h202);
    tbl[3]  = mk(`EXE_LW_OP,  32'h101, 32'h0,        32'h0,    5'd4,  1'b1, 32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0);
    tbl[4]  = mk(`EXE_LBU_OP, 32'h100, 32'h0,        32'h0,    5'd9,  1'b1, 32'h80AA55CC, 0, 0, 1'b0, 4'b1000, 32'h0,        32'h00000080);
    tbl[5]  = mk(`EXE_LH_OP,  32'h200, 32'h0,        32'h0,    5'd10, 1'b1, 32'h80017FFF, 1, 1, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001);
    tbl[6]  = mk(`EXE_SB_OP,  32'h3,   32'h123456AB, 32'h3,    5'd0,  1'b0, 32'h0,        1, 0, 1'b0, 4'b0001, 32'hABABABAB, 32'h3);
    tbl[7]  = mk(`EXE_SW_OP,  32'h40,  32'hDEADBEEF, 32'h40,   5'd0,  1'b0, 32'h0,        0, 2, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h40);
    tbl[8]  = mk(`EXE_LH_OP,  32'h201, 32'h0,        32'h0,    5'd11, 1'b1, 32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0);
    tbl[9]  = mk(`EXE_LW_OP,  32'h300, 32'h0,        32'h0,    5'd12, 1'b1, 32'hCAFEF00D, 3, 0, 1'b0, 4'b1111, 32'h0,        32'hCAFEF00D);
    tbl[10] = mk(`EXE_LHU_OP, 32'h102, 32'h0,        32'h0,    5'd13, 1'b1, 32'h1234F00D, 0, 0, 1'b0, 4'b0011, 32'h0,        32'h0000F00D);
    ops = '{`EXE_LB_OP, `EXE_LBU_OP, `EXE_LH_OP, `EXE_LHU_OP, `EXE_LW_OP,
            `EXE_SB_OP, `EXE_SH_OP, `EXE_SW_OP, `EXE_ADD_OP};

    // Reset holds every output at zero even with a live memory op presented.
    rst = 1'b0; stall = 6'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    mem_aluop_i = `EXE_LW_OP; mem_addr_i = 32'h101; mem_reg2_i = 32'h55; mem_wdata_i = 32'hFFFFFFFF;
    mem_wd_i = 5'h1F; mem_wreg_i = 1'b1; mem_hi_i = 32'h1; mem_lo_i = 32'h2; mem_hilo_i = 1'b1;
    #2;
    chk("rst_wd", mem_wd, 32'h0);
    chk("rst_wreg", mem_wreg, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_hi", mem_hi, 32'h0);
    chk("rst_hilo", mem_hilo, 32'h0);
    chk("rst_stallreq", stallreq, 32'h0);
    chk("rst_misalign", misalign, 32'h0);
    chk("rst_bus_req", bus_req, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_sel", bus_sel, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_err", bus_err, 32'h0);
    @(posedge clk); #3; rst = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) run(tbl[i]);

    // Reset asserted in the middle of a REQ.
    mem_aluop_i = `EXE_LW_OP; mem_addr_i = 32'h500; mem_wreg_i = 1'b1; mem_wd_i = 5'd3; bus_ack = 1'b0;
    #2; chk("rq_stallreq", stallreq, 32'h1);
    tick();
    #2; chk("rq_bus_req", bus_req, 32'h1);
    rst = 1'b0;
    #1;
    chk("rst_mid_bus_req", bus_req, 32'h0);
    chk("rst_mid_stallreq", stallreq, 32'h0);
    chk("rst_mid_wreg", mem_wreg, 32'h0);
    tick();
    mem_aluop_i = `EXE_ADD_OP;
    #2; rst = 1'b1;
    #1;
    chk("post_rst_stallreq", stallreq, 32'h0);
    chk("post_rst_bus_req", bus_req, 32'h0);
    tick();
    run(mk(`EXE_LHU_OP, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1, 32'h80015A5A, 1, 0, 1'b0, 4'b1100, 32'h0, 32'h00008001));

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v = mk(ops[$urandom_range(0, 8)], $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
             $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, 4'h0, 32'h0, 32'h0);
      run(model(v));
    end

`ifdef BUS_TIMEOUT_EN
    // No ack ever: abandoned after four REQ cycles with a one-cycle bus_err.
    mem_aluop_i = `EXE_LW_OP; mem_addr_i = 32'h40; mem_wreg_i = 1'b1; mem_wd_i = 5'd9;
    mem_wdata_i = 32'h1111; bus_ack = 1'b0; stall = 6'b0;
    #2;
    tick();
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("to_bus_req", bus_req, 32'h1);
      chk("to_bus_err_early", bus_err, 32'h0);
      tick();
    end
    #2;
    chk("to_done_bus_req", bus_req, 32'h0);
    chk("to_bus_err", bus_err, 32'h1);
    chk("to_wreg", mem_wreg, 32'h0);
    chk("to_wdata", mem_wdata, 32'h0);
    chk("to_stallreq", stallreq, 32'h0);
    mem_aluop_i = `EXE_ADD_OP;
    tick();
    #2;
    chk("to_err_pulse", bus_err, 32'h0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Non-memory instructions pass straight through combinationally to the MEM/WB inputs.
- Loads and stores run a req/ack transaction on the data bus. The stage holds the pipeline through stallreq until the bus acknowledges.
- Load data is formatted big-endian, with sign or zero extension, before it is handed to write-back.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of REQ cycles without bus_ack before the access is abandoned. Used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- stall  in  6  pipeline stall vector; this block uses stall[4] (MEM held).
- mem_wd_i  in  5  destination register address.
- mem_wreg_i  in  1  register write enable.
- mem_wdata_i  in  32  ALU result.
- mem_hi_i, mem_lo_i  in  32 each  HI/LO values.
- mem_hilo_i  in  1  HI/LO write enable.
- mem_aluop_i  in  8  operation code, compared against the `EXE_*_OP macros in defines.v.
- mem_addr_i  in  32  effective address.
- mem_reg2_i  in  32  store source data.
- mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_hilo  out  5/1/32/32/32/1  to MEM/WB.
- stallreq  out  1  stall request to the controller.
- bus_req  out  1  data-bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address, {mem_addr_i[31:2],2'b00}.
- bus_sel  out  4  byte lanes.
- bus_wdata  out  32  write data.
- bus_rdata  in  32  read data.
- bus_ack  in  1  single-cycle acknowledge.
- misalign  out  1  misaligned access flagged this cycle.
- bus_err  out  1  timeout pulse.

Behaviour:
- Reset (rst=0, takes effect immediately): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0; captured result=0; stallreq=0; misalign=0; bus_err=0. The MEM/WB-facing outputs are forced to 0 / `writeDisable / `NOPRegAddr. Reset mid-transaction drops bus_req in the same cycle.
- FSM states: IDLE, REQ, DONE.
- IDLE, non-memory op:
  - All MEM/WB outputs equal their _i inputs; stallreq=0.
- IDLE, memory op (`EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP):
  - Alignment check: halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Misaligned: no bus access, misalign=1 combinationally, mem_wreg=0, stallreq=0, stay IDLE.
  - Aligned: stallreq=1 combinationally. On the next edge, register bus_req=1, bus_we (stores), bus_addr, bus_sel, bus_wdata; latch wd, wreg and op; go to REQ.
- Byte-lane rules (big-endian):
  - Byte at offset 00/01/10/11 → bus_sel 1000/0100/0010/0001, lane [31:24]/[23:16]/[15:8]/[7:0].
  - Halfword at offset 00 → bus_sel 1100; at offset 10 → bus_sel 0011.
  - Word → bus_sel 1111.
  - Store data is replicated across lanes: SB {4{b}}, SH {2{h}}, SW as-is.
- REQ:
  - stallreq=1; bus outputs held stable.
  - On bus_ack=1: bus_req drops on the next edge. Loads capture the extracted lane (LB/LH sign-extend, LBU/LHU zero-extend, LW raw). Go to DONE.
  - No response on bus_rdata is required when bus_ack=0.
- DONE:
  - stallreq=0. MEM/WB outputs come from the latched wd/wreg; mem_wdata = captured load data (stores: the latched mem_wdata_i); mem_hilo=0.
  - If stall[4]=1, stay in DONE, because a downstream stall is holding MEM. Otherwise go to IDLE.
  - The DONE cycle is never re-evaluated as a new access.
- Latency: minimum 3 cycles in the stage (IDLE, REQ with ack in the same cycle, DONE), i.e. 2 stall cycles. Each wait cycle adds one.
- bus_ack seen in IDLE or DONE is ignored.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments every REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop bus_req and go to DONE with mem_wreg=0 and mem_wdata=0; bus_err=1 for exactly the first DONE cycle.
  - An ack arriving in the same cycle as the timeout wins.
- Undefined: REQ waits indefinitely; bus_err is tied to 0; no counter is built.

Test Plan:
- Pass-through: `EXE_ADD_OP, wd=5, wreg=1, wdata=32'h1234 → identical values on the outputs in the same cycle; stallreq=0; bus_req never set.
- LB, addr=32'h103, bus_rdata=32'h000000F0, ack after 2 wait cycles:
  - bus_sel=0001, bus_addr=32'h100;
  - stallreq high for 4 cycles;
  - DONE presents mem_wdata=32'hFFFFFFF0.
- SH, addr=32'h202, reg2=32'hABCD1234, ack same cycle:
  - bus_we=1, bus_sel=0011, bus_wdata=32'h12341234;
  - 2 stall cycles; mem_wreg=0 in DONE.
- LW at addr=32'h101 → misalign=1, no bus_req, mem_wreg=0, stallreq=0.
- Reset at the REQ midpoint: rst low → bus_req=0 and state IDLE immediately; after release, the next LHU at addr 32'h0 with rdata 32'h8001xxxx → 32'h00008001.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES=4, ack never asserted → bus_req drops after 4 REQ cycles, bus_err pulses 1 cycle, mem_wreg=0.
